// File: rtl/jb_encoder_8to3_irq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jb_encoder_8to3_irq - queues falling edges on 8 active-low lines and presents
// them as a 3-bit index over valid/ready; JB_ENCODER_ONEHOT_OUT_EN adds dout_onehot_n.
// Rev 1.0
// ---------------------------------------------------------------------------
module jb_encoder_8to3_irq #(
  parameter int SYNC_STAGES = 2,
  parameter int ROTATE      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din_n,
  output logic [2:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] pending,
  output logic       overflow,
  input  logic       clr_ovf
`ifdef JB_ENCODER_ONEHOT_OUT_EN
  ,
  output logic [7:0] dout_onehot_n
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] s_d;
  logic [7:0] rise;
  logic [7:0] clr_mask;
  logic [7:0] lost;
  logic [2:0] search_start;
  logic [2:0] sel;
  logic [2:0] idx;
  logic       has_pend;
  logic       load;
  logic [0:0] state;
  logic [0:0] state_nx;

  // History flops reset inactive so a line held low through reset reports once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
      s_d <= 8'hFF;
    end else begin
      sync_q[0] <= din_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = s_d & ~sync_q[SYNC_STAGES-1];
  assign has_pend = |pending;
  assign load     = has_pend && ((state == ST_EMPTY) || dout_ready);

  generate
    if (ROTATE != 0) begin : g_rotate
      logic [2:0] last_grant;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_grant <= 3'd7;
        else if (load) last_grant <= sel;
      end
      assign search_start = last_grant + 3'd1;
    end else begin : g_fixed
      assign search_start = 3'd0;
    end
  endgenerate

  // Walk downward so the closest set bit to search_start is written last.
  always_comb begin
    sel = 3'd0;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = search_start + 3'(k);
      if (pending[idx]) sel = idx;
    end
  end

  assign clr_mask = load ? (8'd1 << sel) : 8'd0;
  assign lost     = rise & pending & ~clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (has_pend)                state_nx = ST_FULL;
      ST_FULL:  if (dout_ready && !has_pend) state_nx = ST_EMPTY;
      default:                               state_nx = ST_EMPTY;
    endcase
  end

  always_comb begin
    dout_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 8'h00;
      overflow <= 1'b0;
      dout     <= 3'd0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      if (|lost)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (load) dout <= sel;
    end
  end

`ifdef JB_ENCODER_ONEHOT_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            dout_onehot_n <= 8'hFF;
    else if (load)                      dout_onehot_n <= ~clr_mask;
    else if (dout_valid && dout_ready)  dout_onehot_n <= 8'hFF;
  end
`endif

endmodule
`default_nettype wire

// File: doc/jb_encoder_8to3_irq.md
Name: jb_encoder_8to3_irq

Overview:
- Sequential 8-to-3 event encoder that works alongside the active-low 3-to-8 decoder.
- Takes eight asynchronous active-low request lines and detects each assertion (falling edge).
- Queues the detected events as pending bits and presents them one at a time as a 3-bit index over a valid/ready handshake.
- Used for interrupt and chip-select event funnelling into register-map logic.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per input line; legal values 2 to 4.
- ROTATE, 0: 0 selects fixed priority, with bit 0 highest; 1 selects round-robin, with the search starting after the last granted index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_n  input  8  asynchronous active-low request lines; a 1-to-0 transition is one event.
- dout  output  3  encoded index of the presented event.
- dout_valid  output  1  dout holds an event.
- dout_ready  input  1  consumer accepts dout when both dout_valid and dout_ready are high.
- pending  output  8  queued events not yet presented.
- overflow  output  1  sticky flag: an event was lost.
- clr_ovf  input  1  single-cycle pulse clears overflow.

Behaviour:
- Reset (asynchronous, active-high):
  - dout=0, dout_valid=0, pending=0, overflow=0.
  - Synchroniser and edge-history flops reset to 8'hFF (inactive).
  - The ROTATE pointer resets to 7, so the first search starts at bit 0.
- Synchronisation: each din_n bit passes through SYNC_STAGES flops; s is the last stage and s_d is s delayed one cycle.
- Edge detect: rise_i = s_d[i] & ~s[i]. Any number of bits may fire in the same cycle; all of them set pending.
- Pending update, per bit and per cycle:
  - pending[i] is cleared when bit i is loaded into the output.
  - pending[i] is set by rise_i. Set wins over clear in the same cycle, with no overflow.
  - rise_i while pending[i]=1 and not being loaded: event is lost, overflow<=1.
- Overflow: clr_ovf clears it; a same-cycle set condition wins.
- Output FSM, two states:
  - EMPTY (dout_valid=0): if pending!=0, go to FULL next cycle. dout <= selected index, dout_valid<=1, clear that pending bit.
  - FULL (dout_valid=1): dout is held stable while dout_ready=0.
  - On handshake with pending!=0 (using the register value before this cycle's updates): reload the next selected index back-to-back and stay in FULL. Throughput is one event per cycle.
  - On handshake with pending==0: go to EMPTY, dout_valid<=0; dout keeps its last value.
- Selection:
  - ROTATE=0: lowest set index of pending.
  - ROTATE=1: first set index searching upward from (last_grant+1) mod 8, wrapping 7 to 0. last_grant updates on each load.
- Latency:
  - Falling edge at the final sync stage to pending set: 1 cycle.
  - pending set to dout_valid high: 1 cycle, if the FSM is EMPTY.
  - Total from a din_n edge: SYNC_STAGES+2 cycles, plus up to 1 cycle of metastability uncertainty.
- Reset mid-operation: the in-flight dout and all pending events are discarded without handshake.
  - A line held low through reset release is reported once, SYNC_STAGES+2 cycles after release, because history resets to inactive. This is intended.
- Width rules: dout is always within 0..7. No X states; an all-zero pending never loads.

Optional Feature:
- Macro: JB_ENCODER_ONEHOT_OUT_EN.
- Defined: adds output port dout_onehot_n [7:0], a registered active-low one-hot of dout.
  - Value is 8'hFF while dout_valid=0; otherwise bit dout is 0 and all others are 1 (dout=5 gives 8'hDF).
  - It updates in the same cycle as dout, so it can drive the decoder's consumer directly.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with din_n=8'hFF for 20 cycles, dout_ready=1 -> dout_valid=0, pending=8'h00, overflow=0 throughout.
- din_n 8'hFF to 8'hDF (SYNC_STAGES=2), dout_ready=1 -> dout_valid=1 with dout=5 exactly 4 cycles after the edge, for 1 cycle; pending[5] visible 1 cycle before; pending=0 afterwards.
- Bits 1 and 6 fall in the same cycle, dout_ready=0 -> pending shows 8'h42, then dout=1 held stable for 10 cycles; dout_ready=1 -> dout=6 the next cycle, then dout_valid=0.
- ROTATE=1: pulse bit 0 and grant it, then pulse bits 0 and 3 together -> dout=3 is presented before dout=0.
- Two falling edges on bit 3 while dout_ready=0 and bit 3 is still pending -> overflow=1 and stays high; clr_ovf pulse -> overflow=0 next cycle.
- Assert rst while dout_valid=1 and din_n[2] is held low; release -> all outputs 0 during reset; dout=2 with dout_valid=1 at 4 cycles after release. With JB_ENCODER_ONEHOT_OUT_EN defined: dout_onehot_n=8'hFB.
